// File: rtl/gem_cluster_pkg.sv
// Shared types and constants for the GEM cluster path: strip-address width,
// the empty-slot threshold and the tagged cluster record.
package gem_cluster_pkg;

  localparam int ADR_W      = 11;
  localparam int N_CLUSTERS = 8;
  localparam int BX_W       = 3;
  // Wide enough to hold a cluster count of 0..N_CLUSTERS
  localparam int N_W        = 4;

  localparam logic [ADR_W-1:0] N_STRIPS = 11'd1536;

  typedef struct packed {
    logic [ADR_W-1:0] adr;
    logic [BX_W-1:0]  bx;
  } cluster_t;

  function automatic logic is_strip(input logic [ADR_W-1:0] a);
    return a < N_STRIPS;
  endfunction

endpackage

// File: rtl/cluster_compactor.sv
// Packs the occupied slots of one BX to the front of an 8-entry array,
// preserving slot order, and reports how many there are.
module cluster_compactor
  import gem_cluster_pkg::*;
(
  input  logic [N_CLUSTERS-1:0] mask_i,
  input  logic [ADR_W-1:0]      adr_i [N_CLUSTERS],
  output logic [ADR_W-1:0]      adr_o [N_CLUSTERS],
  output logic [N_W-1:0]        n_o
);

  // pos[i] = number of occupied slots strictly below slot i
  logic [N_W-1:0] pos [N_CLUSTERS];

  for (genvar gi = 0; gi < N_CLUSTERS; gi++) begin : g_pos
    assign pos[gi] = N_W'($countones(mask_i & N_CLUSTERS'((1 << gi) - 1)));
  end

  for (genvar gi = 0; gi < N_CLUSTERS; gi++) begin : g_out
    logic [ADR_W-1:0] sel;
    always_comb begin
      sel = '0;
      for (int i = 0; i < N_CLUSTERS; i++) begin
        if (mask_i[i] && (pos[i] == N_W'(gi))) sel = adr_i[i];
      end
    end
    assign adr_o[gi] = sel;
  end

  assign n_o = N_W'($countones(mask_i));

endmodule

// File: rtl/cluster_fifo_serializer.sv
// Buffers up to 8 clusters per BX, tags them with a 3-bit BX number and
// streams them out one per clock4x cycle; excess clusters are dropped and counted.
module cluster_fifo_serializer
  import gem_cluster_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                          clock4x,
  input  logic                          reset_n,
  input  logic                          bx_strobe,
  input  logic [ADR_W-1:0]              adr0,
  input  logic [ADR_W-1:0]              adr1,
  input  logic [ADR_W-1:0]              adr2,
  input  logic [ADR_W-1:0]              adr3,
  input  logic [ADR_W-1:0]              adr4,
  input  logic [ADR_W-1:0]              adr5,
  input  logic [ADR_W-1:0]              adr6,
  input  logic [ADR_W-1:0]              adr7,
  output logic                          cluster_valid,
  output logic [ADR_W-1:0]              cluster_adr,
  output logic [BX_W-1:0]               cluster_bx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [CNT_W-1:0]              dropped_cnt
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_FW = PTR_W + 1;

  logic [ADR_W-1:0]      adr_in [N_CLUSTERS];
  logic [N_CLUSTERS-1:0] mask_in;

  assign adr_in[0] = adr0;
  assign adr_in[1] = adr1;
  assign adr_in[2] = adr2;
  assign adr_in[3] = adr3;
  assign adr_in[4] = adr4;
  assign adr_in[5] = adr5;
  assign adr_in[6] = adr6;
  assign adr_in[7] = adr7;

  for (genvar gi = 0; gi < N_CLUSTERS; gi++) begin : g_mask
    assign mask_in[gi] = is_strip(adr_in[gi]);
  end

  // Stage 1: capture the BX snapshot and its tag
  logic                  s1_valid_q;
  logic [N_CLUSTERS-1:0] s1_mask_q;
  logic [ADR_W-1:0]      s1_adr_q [N_CLUSTERS];
  logic [BX_W-1:0]       s1_bx_q;
  logic [BX_W-1:0]       bx_cnt_q;

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_mask_q  <= '0;
      s1_bx_q    <= '0;
      bx_cnt_q   <= '0;
      for (int i = 0; i < N_CLUSTERS; i++) s1_adr_q[i] <= '0;
    end else begin
      s1_valid_q <= bx_strobe;
      if (bx_strobe) begin
        s1_mask_q <= mask_in;
        s1_bx_q   <= bx_cnt_q;
        bx_cnt_q  <= bx_cnt_q + BX_W'(1);
        for (int i = 0; i < N_CLUSTERS; i++) s1_adr_q[i] <= adr_in[i];
      end
    end
  end

  logic [ADR_W-1:0] comp_adr [N_CLUSTERS];
  logic [N_W-1:0]   comp_n;

  cluster_compactor u_compactor (
    .mask_i (s1_mask_q),
    .adr_i  (s1_adr_q),
    .adr_o  (comp_adr),
    .n_o    (comp_n)
  );

  logic [CNT_FW-1:0] count_q, count_d;
  logic [CNT_FW-1:0] free, n_ext, wr_k, drop_n;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              pop;

  // Free space is taken before this cycle's pop, so a pop never makes room
  always_comb begin
    free     = CNT_FW'(FIFO_DEPTH) - count_q;
    n_ext    = s1_valid_q ? CNT_FW'(comp_n) : '0;
    wr_k     = (n_ext > free) ? free : n_ext;
    drop_n   = n_ext - wr_k;
    pop      = (count_q != '0);
    count_d  = count_q + wr_k - CNT_FW'(pop);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_k);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop);
  end

  // Stage 2: each entry decides whether it is one of the k slots written now
  cluster_t              mem_q [FIFO_DEPTH];
  cluster_t              wdata [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] we;

  for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr
    logic [PTR_W-1:0] off;
    assign off       = PTR_W'(gi) - wr_ptr_q;
    assign we[gi]    = CNT_FW'(off) < wr_k;
    assign wdata[gi] = '{adr: comp_adr[off[2:0]], bx: s1_bx_q};
  end

  always_ff @(posedge clock4x) begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (we[i]) mem_q[i] <= wdata[i];
    end
  end

  logic              valid_q;
  logic [ADR_W-1:0]  adr_q;
  logic [BX_W-1:0]   bx_q;
  logic              ovf_q, ovf_d;
  logic [CNT_W-1:0]  dropped_q, dropped_d;
  logic [CNT_W:0]    drop_sum;

  assign drop_sum = {1'b0, dropped_q} + (CNT_W+1)'(drop_n);

  always_comb begin
    ovf_d     = ovf_q;
    dropped_d = dropped_q;
    if (drop_n != '0) begin
      ovf_d     = 1'b1;
      dropped_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clock4x or negedge reset_n) begin
    if (!reset_n) begin
      count_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      valid_q   <= 1'b0;
      adr_q     <= '0;
      bx_q      <= '0;
      ovf_q     <= 1'b0;
      dropped_q <= '0;
    end else begin
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      valid_q   <= pop;
      ovf_q     <= ovf_d;
      dropped_q <= dropped_d;
      if (pop) begin
        adr_q <= mem_q[rd_ptr_q].adr;
        bx_q  <= mem_q[rd_ptr_q].bx;
      end
    end
  end

  assign cluster_valid = valid_q;
  assign cluster_adr   = adr_q;
  assign cluster_bx    = bx_q;
  assign fifo_count    = count_q;
  assign overflow      = ovf_q;
  assign dropped_cnt   = dropped_q;

endmodule
